car_sensor_event_sequencer: RTL and testbench
=============================================

Name: car_sensor_event_sequencer

Overview:
Avalon-MM master that services the 8-input CarSensors edge-capture PIO: programs its irq mask, and on each interrupt reads edge_capture, clears exactly the bits it read, and timestamps the result. Each service yields one event {timestamp, sensor bits}, pushed into an internal FIFO drained by a valid/ready consumer (lap-timing logic or the HPS bridge). This removes per-edge CPU interrupt servicing.

Parameters:
SENS_W, 8, sensor bit count; matches PIO width.
TS_W, 24, free-running timestamp width in clk cycles; wraps.
FIFO_DEPTH, 16, event FIFO entries; power of 2, >= 2.
INIT_MASK, 8'hFF, value written to the PIO irq_mask after reset.

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
enable  in  1  permits starting new service sequences
pio_address  out  2  PIO register address
pio_chipselect  out  1  PIO select
pio_write_n  out  1  active-low write strobe
pio_writedata  out  32  PIO write data; upper bits 0
pio_readdata  in  32  PIO read data; registered in the PIO, valid the cycle after address is presented
pio_irq  in  1  PIO interrupt
evt_valid  out  1  FIFO non-empty
evt_ready  in  1  consumer pop
evt_data  out  TS_W+SENS_W  {timestamp, sensor bits} of FIFO head
evt_count  out  log2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky: event dropped because FIFO full
overflow_clr  in  1  clears overflow

Behaviour:
- Reset values: pio_chipselect 0, pio_write_n 1, pio_address 0, pio_writedata 0, evt_valid 0, evt_count 0, overflow 0, timestamp counter 0, FSM in INIT.
- Timestamp counter increments every clk and wraps modulo 2^TS_W.
- FSM states:
  - INIT: one cycle; chipselect=1, write_n=0, address=2, writedata=INIT_MASK. Next state IDLE. Runs after every reset, regardless of enable.
  - IDLE: bus idle. If pio_irq && enable, latch the timestamp (value in this cycle) and go to RD_ADDR.
  - RD_ADDR: chipselect=1, write_n=1, address=3. Next state RD_DATA.
  - RD_DATA: bus idle; capture pio_readdata[SENS_W-1:0] at end of cycle. If the captured bits are 0 (spurious), go to IDLE with no clear and no push; otherwise go to CLEAR.
  - CLEAR: chipselect=1, write_n=0, address=3, writedata=captured bits. Next state PUSH.
  - PUSH: push {ts, bits} into the FIFO. Next state IDLE.
- Latency: pio_irq high in IDLE cycle T gives the read in T+1, the clear in T+3, the push in T+4, and evt_valid high in T+5 if the FIFO was empty. pio_irq falls in T+4 unless new edges arrived.
- Clear writes only the captured bits. An edge arriving after the read stays set in the PIO, irq remains high, and it is serviced by a new sequence. No edge is lost.
- enable low: an in-progress sequence completes; no new sequence starts.
- FIFO behaviour:
  - First-word-fall-through: evt_data is the head while evt_valid=1.
  - Pop when evt_valid && evt_ready.
  - Push when full with no pop in the same cycle: event dropped and overflow set.
  - Push when full with a pop in the same cycle: accepted; count unchanged.
  - Push and pop in the same cycle when non-empty and not full: count unchanged.
  - Empty: evt_ready ignored.
- overflow_clr clears overflow. If a drop occurs in the same cycle as overflow_clr, overflow stays 1 (set wins).
- Reset mid-sequence returns to INIT, flushes the FIFO, and deasserts the bus immediately. The PIO's own reset clears its state as well.

Test Plan:
- Reset release -> first cycle chipselect=1, write_n=0, address=2, writedata=0xFF; then bus idle with irq low.
- Model PIO, pulse sensor 3 at cycle 100 (irq high at ~103) -> read addr 3, clear write writedata=0x08; evt_data={ts at irq cycle, 0x08}, evt_valid 5 cycles after irq seen, evt_count=1.
- Sensors 0 and 5 edge together, then sensor 1 edges between read and clear -> first event bits 0x21, clear 0x21; irq stays high; second event bits 0x02.
- evt_ready=0, generate 17 events with FIFO_DEPTH=16 -> evt_count=16, overflow=1, 17th dropped. overflow_clr -> overflow=0. Drain -> 16 events in order, timestamps non-decreasing mod 2^24.
- FIFO full with evt_ready=1 in the PUSH cycle -> push accepted, count stays 16, overflow stays 0. enable=0 with irq high -> no bus cycles.
- Assert reset_n low during CLEAR -> chipselect=0 and write_n=1 immediately, evt_valid=0, evt_count=0; after release, INIT write recurs.

Source files
------------

// File: rtl/car_sensor_event_sequencer.sv
// Avalon-MM master servicing an edge-capture PIO and
// queueing timestamped sensor events in a FWFT FIFO.
module car_sensor_event_sequencer #(
  parameter int SENS_W = 8,
  parameter int TS_W = 24,
  parameter int FIFO_DEPTH = 16,
  parameter logic [SENS_W-1:0] INIT_MASK = 8'hFF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic [1:0] pio_address,
  output logic pio_chipselect,
  output logic pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  input  logic pio_irq,
  output logic evt_valid,
  input  logic evt_ready,
  output logic [TS_W+SENS_W-1:0] evt_data,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic overflow,
  input  logic overflow_clr
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = TS_W + SENS_W;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_CLEAR,
    S_PUSH
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [TS_W-1:0] ts;
  logic [TS_W-1:0] ts_evt;
  logic [SENS_W-1:0] bits;
  logic cs_c;
  logic wn_c;
  logic [1:0] addr_c;
  logic [31:0] wd_c;
  logic start;

  logic push;
  logic pop;
  logic full;
  logic accept;
  logic drop;
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign start = (state == S_IDLE) && pio_irq && enable;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_INIT;
      ts     <= '0;
      ts_evt <= '0;
      bits   <= '0;
    end else begin
      state <= state_nxt;
      ts    <= ts + TS_W'(1);
      if (start) begin
        ts_evt <= ts;
      end
      if (state == S_RD_DATA) begin
        bits <= pio_readdata[SENS_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cs_c      = 1'b0;
    wn_c      = 1'b1;
    addr_c    = 2'd0;
    wd_c      = 32'd0;
    unique case (state)
      S_INIT: begin
        cs_c      = 1'b1;
        wn_c      = 1'b0;
        addr_c    = 2'd2;
        wd_c      = 32'(INIT_MASK);
        state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        cs_c      = 1'b1;
        addr_c    = 2'd3;
        state_nxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        // nothing captured means the irq was spurious
        if (pio_readdata[SENS_W-1:0] == '0) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cs_c      = 1'b1;
        wn_c      = 1'b0;
        addr_c    = 2'd3;
        wd_c      = 32'(bits);
        state_nxt = S_PUSH;
      end
      S_PUSH: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_INIT;
      end
    endcase
  end

  // INIT is the reset state, so the strobes are held off while in reset
  assign pio_chipselect = cs_c & reset_n;
  assign pio_write_n    = wn_c | ~reset_n;
  assign pio_address    = reset_n ? addr_c : 2'd0;
  assign pio_writedata  = reset_n ? wd_c : 32'd0;

  assign push      = (state == S_PUSH);
  assign evt_valid = (evt_count != '0);
  assign pop       = evt_valid && evt_ready;
  assign full      = (evt_count == CW'(FIFO_DEPTH));
  assign accept    = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign evt_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {ts_evt, bits};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({accept, pop})
        2'b10:   evt_count <= evt_count + CW'(1);
        2'b01:   evt_count <= evt_count - CW'(1);
        default: evt_count <= evt_count;
      endcase
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end

endmodule

// File: tb/tb_car_sensor_event_sequencer.sv
// Bench for car_sensor_event_sequencer: PIO model,
// directed steps and an event scoreboard.
module tb_car_sensor_event_sequencer;
  localparam int TS_W = 24;
  localparam int EW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b1;
  logic [1:0] pio_address;
  logic pio_chipselect;
  logic pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic pio_irq;
  logic evt_valid;
  logic evt_ready = 1'b0;
  logic [EW-1:0] evt_data;
  logic [4:0] evt_count;
  logic overflow;
  logic overflow_clr = 1'b0;

  int tests = 0;
  int failed = 0;
  int bus_cycles = 0;
  int n_reads = 0;
  int skip_idx = -1;

  logic [7:0] cap;
  logic [7:0] mask;
  logic [7:0] sens = 8'h00;
  logic [TS_W-1:0] tsm;
  logic [EW-1:0] exp_q[$];
  logic [7:0] clr_q[$];
  logic [7:0] exp_c;
  logic rd_cyc;
  logic clr_cyc;
  logic [TS_W-1:0] t_ts;
  int b0;

  always #5 clk = ~clk;

  car_sensor_event_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .pio_address(pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n),
    .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata),
    .pio_irq(pio_irq),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_count(evt_count),
    .overflow(overflow),
    .overflow_clr(overflow_clr)
  );

  assign rd_cyc = pio_chipselect && pio_write_n && (pio_address == 2'd3);
  assign clr_cyc = pio_chipselect && !pio_write_n && (pio_address == 2'd3);
  assign pio_irq = |(cap & mask);

  // edge-capture PIO: registered readdata, write-1-to-clear, new edges win
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap <= 8'h00;
      mask <= 8'h00;
      pio_readdata <= 32'h0;
    end else begin
      pio_readdata <= (pio_address == 2'd3) ? {24'h0, cap} :
                      (pio_address == 2'd2) ? {24'h0, mask} : 32'h0;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2)
        mask <= pio_writedata[7:0];
      if (clr_cyc)
        cap <= (cap & ~pio_writedata[7:0]) | sens;
      else
        cap <= cap | sens;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tsm <= '0;
    else tsm <= tsm + 24'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      clr_q.delete();
    end else begin
      if (pio_chipselect) bus_cycles++;
      if (rd_cyc && cap != 8'h00) begin
        if (n_reads != skip_idx) exp_q.push_back({tsm - 24'd1, cap});
        clr_q.push_back(cap);
        n_reads++;
      end
      if (clr_cyc) begin
        if (clr_q.size() == 0) chk("clr_unexpected", 1, 0);
        else begin
          exp_c = clr_q.pop_front();
          chk("clr_data", pio_writedata, {24'h0, exp_c});
        end
      end
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) chk("evt_unexpected", 1, 0);
        else chk("evt_data", evt_data, exp_q.pop_front());
      end
    end
  end

  task automatic pulse(input logic [7:0] m);
    @(negedge clk);
    sens = m;
    @(negedge clk);
    sens = 8'h00;
  endtask

  task automatic wait_count(input int n, input string tag);
    for (int i = 0; i < 40 && evt_count != 5'(n); i++) @(negedge clk);
    chk(tag, evt_count, 5'(n));
  endtask

  task automatic drain(input string tag);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    for (int i = 0; i < 40 && evt_valid; i++) @(posedge clk);
    #1 evt_ready = 1'b0;
    chk(tag, evt_valid, 0);
    chk({tag, "_sb"}, exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wn", pio_write_n, 1);
    chk("rst_addr", pio_address, 0);
    chk("rst_wd", pio_writedata, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("init_cs", pio_chipselect, 1);
    chk("init_wn", pio_write_n, 0);
    chk("init_addr", pio_address, 2);
    chk("init_wd", pio_writedata, 32'hFF);
    @(negedge clk);
    chk("idle_cs", pio_chipselect, 0);
    chk("idle_irq", pio_irq, 0);

    // single edge, exact latency
    repeat (95) @(negedge clk);
    pulse(8'h08);
    chk("s3_irq", pio_irq, 1);
    t_ts = tsm;
    @(negedge clk);
    chk("s3_read", rd_cyc, 1);
    @(negedge clk);
    chk("s3_gap", pio_chipselect, 0);
    @(negedge clk);
    chk("s3_clr", clr_cyc, 1);
    chk("s3_clr_wd", pio_writedata, 32'h08);
    @(negedge clk);
    chk("s3_irq_low", pio_irq, 0);
    chk("s3_not_yet", evt_valid, 0);
    @(negedge clk);
    chk("s3_valid", evt_valid, 1);
    chk("s3_count", evt_count, 1);
    chk("s3_data", evt_data, {t_ts, 8'h08});
    drain("s3_drain");

    // edge arriving between read and clear survives
    repeat (3) @(negedge clk);
    pulse(8'h21);
    @(negedge clk);
    chk("race_read", rd_cyc, 1);
    sens = 8'h02;
    @(negedge clk);
    sens = 8'h00;
    @(negedge clk);
    chk("race_clr_wd", pio_writedata, 32'h21);
    @(negedge clk);
    chk("race_irq_held", pio_irq, 1);
    wait_count(2, "race_count");
    drain("race_drain");

    // fill to 16, drop the 17th
    skip_idx = n_reads + 16;
    for (int i = 0; i < 16; i++) begin
      pulse(8'(1 << (i % 8)));
      repeat (8) @(negedge clk);
    end
    chk("fill_count", evt_count, 16);
    chk("fill_ovf", overflow, 0);
    pulse(8'h04);
    repeat (8) @(negedge clk);
    chk("drop_count", evt_count, 16);
    chk("drop_ovf", overflow, 1);
    @(posedge clk);
    #1 overflow_clr = 1'b1;
    @(posedge clk);
    #1 overflow_clr = 1'b0;
    @(negedge clk);
    chk("ovf_clr", overflow, 0);

    // full FIFO with a pop in the PUSH cycle
    pulse(8'h40);
    repeat (3) @(negedge clk);
    chk("full_clr", clr_cyc, 1);
    @(posedge clk);
    #1 evt_ready = 1'b1;
    @(posedge clk);
    #1 evt_ready = 1'b0;
    @(negedge clk);
    chk("full_pop_count", evt_count, 16);
    chk("full_pop_ovf", overflow, 0);
    drain("full_drain");

    // enable low blocks new sequences
    enable = 1'b0;
    b0 = bus_cycles;
    pulse(8'h80);
    repeat (20) @(negedge clk);
    chk("dis_bus", bus_cycles, b0);
    chk("dis_irq", pio_irq, 1);
    enable = 1'b1;
    wait_count(1, "dis_resume");
    drain("dis_drain");

    // reset during CLEAR
    pulse(8'h10);
    repeat (8) @(negedge clk);
    chk("pre_rst_count", evt_count, 1);
    pulse(8'h04);
    repeat (3) @(negedge clk);
    chk("pre_rst_clr", clr_cyc, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_cs", pio_chipselect, 0);
    chk("mid_rst_wn", pio_write_n, 1);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_count", evt_count, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("reinit_cs", pio_chipselect, 1);
    chk("reinit_wn", pio_write_n, 0);
    chk("reinit_addr", pio_address, 2);
    chk("reinit_wd", pio_writedata, 32'hFF);
    @(negedge clk);
    chk("reidle_cs", pio_chipselect, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
